mips_mmio_txport: RTL and testbench

- Memory-mapped output port that acts as the responder on the 8-bit MIPS memory bus (memwrite/adr/writedata).
- CPU stores to a data address and are queued in a small FIFO; an external consumer drains the FIFO with a valid/ready handshake.
- A status register is readable by the CPU, so programs can poll for space and report results in hardware rather than through a bench monitor.
- Sits beside the existing memory inside mips_mem; the memory ignores any access for which this block's sel is high.

---
 rtl/mips_mmio_txport.sv | 81 ++++++++
 tb/tb_mips_mmio_txport.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mips_mmio_txport.sv
// Memory-mapped transmit port on the 8-bit MIPS bus: CPU stores to TXDATA_ADR
// are queued in a small FIFO, drained by an external valid/ready consumer.
module mips_mmio_txport #(
    parameter int             WIDTH      = 8,
    parameter int             DEPTH      = 4,
    parameter logic [WIDTH-1:0] TXDATA_ADR = 8'hFC,
    parameter logic [WIDTH-1:0] STATUS_ADR = 8'hFD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic             sel,
    output logic [WIDTH-1:0] readdata,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rptr, r_wptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic             w_hit_tx, w_hit_st;
    logic             w_push, w_pop, w_full, w_empty;
    logic             w_accept, w_drop, w_clear;
    logic [4:0]       w_cnt5;
    logic [7:0]       w_status;

    assign w_hit_tx = (adr == TXDATA_ADR);
    assign w_hit_st = (adr == STATUS_ADR);
    assign sel      = w_hit_tx | w_hit_st;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_push   = memwrite & w_hit_tx;
    assign w_pop    = ~w_empty & out_ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;
    assign w_clear  = memwrite & w_hit_st & writedata[2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) r_wptr <= r_wptr + 1'b1;
            if (w_pop)    r_rptr <= r_rptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)       r_overflow <= 1'b1;
            else if (w_clear) r_overflow <= 1'b0;
        end
    end

    // Storage is deliberately left out of reset; the output mux hides stale entries.
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wptr] <= writedata;
    end

    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rptr];
    assign overflow  = r_overflow;

    assign w_cnt5   = 5'(r_count);
    assign w_status = {w_cnt5, r_overflow, w_full, w_empty};
    assign readdata = w_hit_st ? WIDTH'(w_status) : '0;

endmodule

// File: tb/tb_mips_mmio_txport.sv
// Directed + randomized bench for mips_mmio_txport, checked against a queue model.
module tb_mips_mmio_txport;
    localparam int DEPTH = 4;
    localparam logic [7:0] FC = 8'hFC, FD = 8'hFD;

    logic       clk = 1'b0, reset = 1'b0;
    logic       memwrite = 1'b0, out_ready = 1'b0;
    logic [7:0] adr = 8'h00, writedata = 8'h00;
    logic       sel, out_valid, overflow;
    logic [7:0] readdata, out_data;

    int n_cmp = 0, n_fail = 0;
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;

    mips_mmio_txport #(.WIDTH(8), .DEPTH(DEPTH), .TXDATA_ADR(FC), .STATUS_ADR(FD)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .writedata(writedata),
        .sel(sel), .readdata(readdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mstat();
        logic [4:0] c;
        c = 5'(q.size());
        return {c, m_ovf, q.size() == DEPTH, q.size() == 0};
    endfunction

    function automatic logic [7:0] mhead();
        return (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".valid"}, {7'b0, out_valid}, {7'b0, q.size() != 0});
        chk({tag, ".data"},  out_data, mhead());
        chk({tag, ".ovf"},   {7'b0, overflow}, {7'b0, m_ovf});
    endtask

    // One bus cycle: drive, check the combinational decode, model the edge, check results.
    task automatic step(input logic mw, input logic [7:0] a, input logic [7:0] wd, input logic rdy);
        bit pop, push;
        memwrite = mw; adr = a; writedata = wd; out_ready = rdy;
        #1;
        chk("sel", {7'b0, sel}, {7'b0, (a == FC) || (a == FD)});
        chk("rd_pre", readdata, (a == FD) ? mstat() : 8'h00);
        pop  = (q.size() != 0) && rdy;
        push = mw && (a == FC);
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEPTH) q.push_back(wd);
            else m_ovf = 1'b1;
        end
        if (mw && a == FD && wd[2]) m_ovf = 1'b0;
        @(posedge clk); #1;
        chk_outputs("post");
        memwrite = 1'b0; adr = FD;
        #1;
        chk("status", readdata, mstat());
    endtask

    initial begin
        // 1: reset
        #22 reset = 1'b1;
        adr = FD; #1;
        chk_outputs("reset");
        chk("reset.status", readdata, 8'h01);

        // 2: single entry
        step(1, FC, 8'hF2, 0);
        chk("t2.status", readdata, 8'h08);
        step(0, 8'h00, 8'h00, 1);
        chk("t2.drain", readdata, 8'h01);

        // 3: fill, overflow, drain
        for (int i = 1; i <= 5; i++) begin
            step(1, FC, 8'(i), 0);
            if (i == 4) chk("t3.full", readdata, 8'h22);
        end
        chk("t3.ovf", readdata, 8'h26);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 8'h00, 1);

        // 4: push into full FIFO while popping
        step(1, FD, 8'h04, 0);
        for (int i = 0; i < 4; i++) step(1, FC, 8'h10 + 8'(i), 0);
        step(1, FC, 8'hAA, 1);
        chk("t4.status", readdata, 8'h22);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 8'h00, 1);

        // 5: overflow clear, no-op control write, foreign address
        for (int i = 0; i < 5; i++) step(1, FC, 8'h30 + 8'(i), 0);
        step(1, FD, 8'h04, 0);
        chk("t5.clr", {7'b0, overflow}, 8'h00);
        step(1, FD, 8'h00, 0);
        step(1, 8'hEE, 8'h55, 0);
        step(0, FC, 8'h00, 0);

        // 6: async reset mid-transfer, then sustained streaming across wrap
        for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 3; i++) step(1, FC, 8'h60 + 8'(i), 0);
        #1 reset = 1'b0;
        q.delete(); m_ovf = 1'b0;
        #1;
        chk_outputs("t6.async");
        #1 reset = 1'b1;
        adr = FD; #1;
        chk("t6.status", readdata, 8'h01);
        for (int i = 0; i < 20; i++) step(1, FC, 8'h80 + 8'(i), 1);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h00, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            case ($urandom_range(0, 3))
                0, 1: a = FC;
                2:    a = FD;
                default: a = 8'($urandom);
            endcase
            step(1'($urandom), a, 8'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
